hit_resolver: RTL and testbench
===============================

HIT_RESOLVER -- requirements
Module: hit_resolver

Interface
REQ-001 Parameter HEALTH_INIT, default 5: health loaded at reset and at round start.
REQ-002 Parameter BLOCK_MAX, default 3: block charges loaded at reset and at round start; regen ceiling.
REQ-003 Parameter REGEN_PERIOD, default 64: in-fight cycles per block-charge regen.
REQ-004 Parameters DMG_BASIC, default 1, and DMG_DIR, default 2: health lost per landed basic / directional hit.
REQ-005 clk  in  1  single system clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 gamestate  in  3  0 = round setup, 2 = fight, other = frozen.
REQ-008 p1_state, p2_state  in  4 each  player FSM state codes (2 = move backwards, 4 = basic attack end, 7 = directional attack end, 9 = hitstun, 10 = blockstun).
REQ-009 p1_boxes, p2_boxes  in  120 each  packed {basic x1,x2,y1,y2; dir x1,x2,y1,y2; main x1,x2,y1,y2}, 10 bits each, MSB-first.
REQ-010 p1_hitFlag, p2_hitFlag  out  2 each  00 none, 01 hit by basic, 10 hit by directional.
REQ-011 p1_health, p2_health  out  3 each  remaining health.
REQ-012 p1_block, p2_block  out  3 each  remaining block charges.
REQ-013 ko  out  1  sticky round-over flag.
REQ-014 winner  out  2  01 P1 wins, 10 P2 wins, 11 double KO, 00 none.

Function
REQ-015 Overlap: inclusive, unsigned; boxes A and B overlap iff A.x1<=B.x2, B.x1<=A.x2, A.y1<=B.y2 and B.y1<=A.y2.
REQ-016 Basic strike: attacker state 4 with attacker basic box overlapping defender main box.
REQ-017 Directional strike: attacker state 7 with attacker dir box overlapping defender main box.
REQ-018 A strike registers only when gamestate==2, ko==0, the attacker's landed latch is clear, and the defender state is not 9 or 10.
REQ-019 On registration: set the attacker's landed latch; drive defender hitFlag with 01/10 on the next cycle for exactly one cycle, then 00.
REQ-020 Landed latch clears on the cycle the attacker's state is neither 4 nor 7; at most one hit per attack swing.
REQ-021 Blocked hit (defender state 2 and defender block>0): block decrements by 1; health unchanged; hitFlag still driven.
REQ-022 Unblocked hit: health decreases by DMG_BASIC or DMG_DIR, saturating at 0.
REQ-023 Health and block update on the same edge the hitFlag asserts.
REQ-024 Simultaneous registrations by both players resolve independently in the same cycle (trade).
REQ-025 Regen: one shared counter increments each gamestate==2 cycle; on wrap at REGEN_PERIOD-1, each player with block<BLOCK_MAX and no block decrement that cycle gains +1.
REQ-026 ko sets on the edge any health becomes 0; winner is captured on the same edge (11 if both 0); both hold until gamestate==0.
REQ-027 gamestate==0: health=HEALTH_INIT, block=BLOCK_MAX, latches, hitFlags, regen counter, ko and winner all cleared, every cycle.
REQ-028 Other gamestate values: all registers hold; hitFlags forced to 00.

Reset
REQ-029 While rst_n=0, asynchronously: health=HEALTH_INIT, block=BLOCK_MAX, hitFlags=00, latches=0, regen counter=0, ko=0, winner=00.
REQ-030 rst_n asserted mid-hit discards the pending hitFlag; the first cycle after release behaves as a fresh round.

Structure
REQ-031 Shared package holds: player state codes, hitFlag codes, gamestate codes, box field offsets in the packed bus.
REQ-032 Sub-module box_overlap, combinational, implements REQ-015 and is instantiated four times (two box types x two directions).

Verification
REQ-033 P1 state 4, P1 basic box {200,278,194,227}, P2 main {230,283,170,320}, P2 idle -> p2_hitFlag=01 for one cycle; p2_health 5->4.
REQ-034 Same strike held 10 cycles in state 4 -> exactly one hitFlag pulse and one decrement; return to 0 then 4 again -> second pulse.
REQ-035 P2 state 2, block=3, P1 directional strike -> p2_hitFlag=10; p2_block 3->2; p2_health unchanged; with block=0 -> health -2.
REQ-036 Both players strike each other at health 1 on the same cycle -> both health 0, ko=1, winner=11; further strikes ignored.
REQ-037 P2 block=1, 64 fight cycles without hits -> block=2 on the wrap edge; at 3 no further increase.
REQ-038 rst_n pulsed low during hitFlag pulse -> outputs immediately at reset values; gamestate 3 -> all values frozen, hitFlags 00.

Source files
------------

// File: rtl/hit_resolver_pkg.sv
// Shared codes, widths and packed-bus layout for the hit resolver.
package hit_resolver_pkg;

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned BOX_W    = 4 * COORD_W;
    localparam int unsigned BUS_W    = 3 * BOX_W;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned GS_W     = 3;
    localparam int unsigned HEALTH_W = 3;
    localparam int unsigned BLOCK_W  = 3;

    // Box positions inside the 120-bit player bus (basic box occupies the MSBs)
    localparam int unsigned BOX_BASIC_LSB = 2 * BOX_W;
    localparam int unsigned BOX_DIR_LSB   = BOX_W;
    localparam int unsigned BOX_MAIN_LSB  = 0;

    // Coordinate order inside one box, x1 in the MSBs
    typedef struct packed {
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] x2;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] y2;
    } box_t;

    typedef enum logic [STATE_W-1:0] {
        PST_MOVE_BACK  = 4'd2,
        PST_BASIC_END  = 4'd4,
        PST_DIR_END    = 4'd7,
        PST_HITSTUN    = 4'd9,
        PST_BLOCKSTUN  = 4'd10
    } pstate_e;

    typedef enum logic [1:0] {
        HF_NONE  = 2'b00,
        HF_BASIC = 2'b01,
        HF_DIR   = 2'b10
    } hitflag_e;

    typedef enum logic [GS_W-1:0] {
        GS_SETUP = 3'd0,
        GS_FIGHT = 3'd2
    } gamestate_e;

    typedef enum logic [1:0] {
        WIN_NONE   = 2'b00,
        WIN_P1     = 2'b01,
        WIN_P2     = 2'b10,
        WIN_DOUBLE = 2'b11
    } winner_e;

endpackage

// File: rtl/hit_resolver_box_overlap.sv
// Combinational inclusive overlap test between two axis-aligned boxes.
module box_overlap
    import hit_resolver_pkg::*;
(
    input  box_t a,
    input  box_t b,
    output logic overlap_c
);

    // Both axes must intersect, edges touching counts as overlap
    always_comb begin
        overlap_c = (a.x1 <= b.x2) && (b.x1 <= a.x2) &&
                    (a.y1 <= b.y2) && (b.y1 <= a.y2);
    end

endmodule

// File: rtl/hit_resolver.sv
// Resolves strikes between two fighters: hit flags, health, block charges, regen and KO.
module hit_resolver
    import hit_resolver_pkg::*;
#(
    parameter int unsigned HEALTH_INIT  = 5,
    parameter int unsigned BLOCK_MAX    = 3,
    parameter int unsigned REGEN_PERIOD = 64,
    parameter int unsigned DMG_BASIC    = 1,
    parameter int unsigned DMG_DIR      = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [GS_W-1:0]     gamestate,
    input  logic [STATE_W-1:0]  p1_state,
    input  logic [STATE_W-1:0]  p2_state,
    input  logic [BUS_W-1:0]    p1_boxes,
    input  logic [BUS_W-1:0]    p2_boxes,
    output logic [1:0]          p1_hitFlag,
    output logic [1:0]          p2_hitFlag,
    output logic [HEALTH_W-1:0] p1_health,
    output logic [HEALTH_W-1:0] p2_health,
    output logic [BLOCK_W-1:0]  p1_block,
    output logic [BLOCK_W-1:0]  p2_block,
    output logic                ko,
    output logic [1:0]          winner
);

    localparam int unsigned CNT_W = (REGEN_PERIOD > 1) ? $clog2(REGEN_PERIOD) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST      = CNT_W'(REGEN_PERIOD - 1);
    localparam logic [HEALTH_W-1:0] HEALTH_INIT_V = HEALTH_W'(HEALTH_INIT);
    localparam logic [BLOCK_W-1:0]  BLOCK_MAX_V   = BLOCK_W'(BLOCK_MAX);
    localparam logic [HEALTH_W-1:0] DMG_BASIC_V   = HEALTH_W'(DMG_BASIC);
    localparam logic [HEALTH_W-1:0] DMG_DIR_V     = HEALTH_W'(DMG_DIR);

    // Index 0 is P1, index 1 is P2
    logic [1:0][STATE_W-1:0]  st_c;
    logic [1:0][BUS_W-1:0]    boxes_c;
    logic [1:0]               land_c;
    logic [1:0][1:0]          kind_c;
    logic [1:0][1:0]          flag_c;
    logic [1:0][HEALTH_W-1:0] health_c;
    logic [1:0][HEALTH_W-1:0] health_nxt_c;
    logic [1:0][BLOCK_W-1:0]  block_c;
    logic                     fight_c;
    logic                     wrap_c;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ko_q, ko_d;
    logic [1:0]       winner_q, winner_d;

    assign st_c    = {p2_state, p1_state};
    assign boxes_c = {p2_boxes, p1_boxes};
    assign fight_c = (gamestate == GS_FIGHT) && !ko_q;
    assign wrap_c  = (gamestate == GS_FIGHT) && (cnt_q == CNT_LAST);

    for (genvar I = 0; I < 2; I++) begin : g_player
        localparam int unsigned D = 1 - I;

        box_t                basic_box_c, dir_box_c, opp_main_c;
        logic                basic_ovl_c, dir_ovl_c;
        logic [1:0]          swing_kind_c;
        logic                blk_dec_c;
        logic [HEALTH_W-1:0] dmg_c;
        logic [1:0]          hit_flag_q, hit_flag_d;
        logic [HEALTH_W-1:0] health_q, health_d;
        logic [BLOCK_W-1:0]  block_q, block_d;
        logic                latch_q, latch_d;

        assign basic_box_c = boxes_c[I][BOX_BASIC_LSB +: BOX_W];
        assign dir_box_c   = boxes_c[I][BOX_DIR_LSB +: BOX_W];
        assign opp_main_c  = boxes_c[D][BOX_MAIN_LSB +: BOX_W];

        box_overlap u_basic (.a(basic_box_c), .b(opp_main_c), .overlap_c(basic_ovl_c));
        box_overlap u_dir   (.a(dir_box_c),   .b(opp_main_c), .overlap_c(dir_ovl_c));

        // Classify this player's current swing as a basic or directional contact
        always_comb begin
            swing_kind_c = HF_NONE;
            if ((st_c[I] == PST_BASIC_END) && basic_ovl_c) begin
                swing_kind_c = HF_BASIC;
            end else if ((st_c[I] == PST_DIR_END) && dir_ovl_c) begin
                swing_kind_c = HF_DIR;
            end
        end

        assign kind_c[I] = swing_kind_c;
        assign land_c[I] = fight_c && !latch_q && (swing_kind_c != HF_NONE) &&
                           (st_c[D] != PST_HITSTUN) && (st_c[D] != PST_BLOCKSTUN);

        // Apply the opponent's landed strike, block regen and this player's swing latch
        always_comb begin
            hit_flag_d = hit_flag_q;
            health_d   = health_q;
            block_d    = block_q;
            latch_d    = latch_q;
            blk_dec_c  = 1'b0;
            dmg_c      = (kind_c[D] == HF_BASIC) ? DMG_BASIC_V : DMG_DIR_V;
            if (gamestate == GS_SETUP) begin
                hit_flag_d = HF_NONE;
                health_d   = HEALTH_INIT_V;
                block_d    = BLOCK_MAX_V;
                latch_d    = 1'b0;
            end else if (gamestate != GS_FIGHT) begin
                hit_flag_d = HF_NONE;
            end else begin
                hit_flag_d = land_c[D] ? kind_c[D] : HF_NONE;
                if (land_c[D]) begin
                    if ((st_c[I] == PST_MOVE_BACK) && (block_q != '0)) begin
                        block_d   = block_q - BLOCK_W'(1);
                        blk_dec_c = 1'b1;
                    end else begin
                        health_d = (health_q > dmg_c) ? health_q - dmg_c : '0;
                    end
                end
                if (wrap_c && !blk_dec_c && (block_q < BLOCK_MAX_V)) begin
                    block_d = block_q + BLOCK_W'(1);
                end
                if ((st_c[I] != PST_BASIC_END) && (st_c[I] != PST_DIR_END)) begin
                    latch_d = 1'b0;
                end else if (land_c[I]) begin
                    latch_d = 1'b1;
                end
            end
        end

        // Per-player state registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hit_flag_q <= HF_NONE;
                health_q   <= HEALTH_INIT_V;
                block_q    <= BLOCK_MAX_V;
                latch_q    <= 1'b0;
            end else begin
                hit_flag_q <= hit_flag_d;
                health_q   <= health_d;
                block_q    <= block_d;
                latch_q    <= latch_d;
            end
        end

        assign flag_c[I]       = hit_flag_q;
        assign health_c[I]     = health_q;
        assign health_nxt_c[I] = health_d;
        assign block_c[I]      = block_q;
    end

    // Shared regen counter and sticky KO / winner capture
    always_comb begin
        cnt_d    = cnt_q;
        ko_d     = ko_q;
        winner_d = winner_q;
        if (gamestate == GS_SETUP) begin
            cnt_d    = '0;
            ko_d     = 1'b0;
            winner_d = WIN_NONE;
        end else if (gamestate == GS_FIGHT) begin
            cnt_d = wrap_c ? '0 : cnt_q + CNT_W'(1);
            if (!ko_q && ((health_nxt_c[0] == '0) || (health_nxt_c[1] == '0))) begin
                ko_d     = 1'b1;
                winner_d = {health_nxt_c[0] == '0, health_nxt_c[1] == '0};
            end
        end
    end

    // Shared state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            ko_q     <= 1'b0;
            winner_q <= WIN_NONE;
        end else begin
            cnt_q    <= cnt_d;
            ko_q     <= ko_d;
            winner_q <= winner_d;
        end
    end

    assign p1_hitFlag = flag_c[0];
    assign p2_hitFlag = flag_c[1];
    assign p1_health  = health_c[0];
    assign p2_health  = health_c[1];
    assign p1_block   = block_c[0];
    assign p2_block   = block_c[1];
    assign ko         = ko_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_hit_resolver.sv
// Scoreboard bench for hit_resolver: directed scenarios followed by random play.
module tb_hit_resolver;

    localparam int HP0 = 5;
    localparam int BMAX = 3;
    localparam int PERIOD = 64;
    localparam int DMG_B = 1;
    localparam int DMG_D = 2;

    typedef struct packed {
        logic [1:0] hf1;
        logic [1:0] hf2;
        logic [2:0] h1;
        logic [2:0] h2;
        logic [2:0] b1;
        logic [2:0] b2;
        logic       ko;
        logic [1:0] win;
    } obs_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   gamestate = '0;
    logic [3:0]   p1_state = '0;
    logic [3:0]   p2_state = '0;
    logic [119:0] p1_boxes = '0;
    logic [119:0] p2_boxes = '0;
    logic [1:0]   p1_hitFlag, p2_hitFlag;
    logic [2:0]   p1_health, p2_health, p1_block, p2_block;
    logic         ko;
    logic [1:0]   winner;

    hit_resolver #(
        .HEALTH_INIT(HP0), .BLOCK_MAX(BMAX), .REGEN_PERIOD(PERIOD),
        .DMG_BASIC(DMG_B), .DMG_DIR(DMG_D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .gamestate(gamestate),
        .p1_state(p1_state), .p2_state(p2_state),
        .p1_boxes(p1_boxes), .p2_boxes(p2_boxes),
        .p1_hitFlag(p1_hitFlag), .p2_hitFlag(p2_hitFlag),
        .p1_health(p1_health), .p2_health(p2_health),
        .p1_block(p1_block), .p2_block(p2_block),
        .ko(ko), .winner(winner)
    );

    always #5 clk = ~clk;

    // Stimulus variables: bx[player][0 basic,1 dir,2 main][x1,x2,y1,y2]
    int gs;
    int st[2];
    bit rst_v;
    int bx[2][3][4];

    // Reference model state
    int m_h[2], m_b[2], m_hf[2], m_latch[2];
    int m_cnt, m_ko, m_win;

    obs_t exp_q[$];
    int checks = 0;
    int failures = 0;

    function automatic logic [119:0] pack(input int p);
        logic [119:0] v;
        v = '0;
        for (int t = 0; t < 3; t++)
            for (int c = 0; c < 4; c++)
                v = {v[109:0], 10'(bx[p][t][c])};
        return v;
    endfunction

    function automatic bit overlaps(input int pa, input int ta, input int pb, input int tb);
        return bx[pa][ta][0] <= bx[pb][tb][1] && bx[pb][tb][0] <= bx[pa][ta][1] &&
               bx[pa][ta][2] <= bx[pb][tb][3] && bx[pb][tb][2] <= bx[pa][ta][3];
    endfunction

    task automatic set_box(input int p, input int t, input int x1, input int x2, input int y1, input int y2);
        bx[p][t][0] = x1; bx[p][t][1] = x2; bx[p][t][2] = y1; bx[p][t][3] = y2;
    endtask

    task automatic model_init();
        for (int i = 0; i < 2; i++) begin
            m_h[i] = HP0; m_b[i] = BMAX; m_hf[i] = 0; m_latch[i] = 0;
        end
        m_cnt = 0; m_ko = 0; m_win = 0;
    endtask

    // One clock edge of the game rules, applied to the inputs just driven
    task automatic model_step();
        int  kind[2];
        bit  land[2];
        bit  dec[2];
        bit  wrap;
        if (!rst_v || gs == 0) begin
            model_init();
            return;
        end
        if (gs != 2) begin
            m_hf[0] = 0; m_hf[1] = 0;
            return;
        end
        for (int a = 0; a < 2; a++) begin
            kind[a] = 0;
            if (st[a] == 4 && overlaps(a, 0, 1 - a, 2)) kind[a] = 1;
            else if (st[a] == 7 && overlaps(a, 1, 1 - a, 2)) kind[a] = 2;
            land[a] = m_ko == 0 && m_latch[a] == 0 && kind[a] != 0 &&
                      st[1 - a] != 9 && st[1 - a] != 10;
        end
        wrap = (m_cnt == PERIOD - 1);
        for (int d = 0; d < 2; d++) begin
            dec[d] = 0;
            m_hf[d] = land[1 - d] ? kind[1 - d] : 0;
            if (land[1 - d]) begin
                if (st[d] == 2 && m_b[d] > 0) begin
                    m_b[d] = m_b[d] - 1;
                    dec[d] = 1;
                end else begin
                    m_h[d] = m_h[d] - (kind[1 - d] == 1 ? DMG_B : DMG_D);
                    if (m_h[d] < 0) m_h[d] = 0;
                end
            end
            if (wrap && !dec[d] && m_b[d] < BMAX) m_b[d] = m_b[d] + 1;
        end
        for (int a = 0; a < 2; a++) begin
            if (st[a] != 4 && st[a] != 7) m_latch[a] = 0;
            else if (land[a]) m_latch[a] = 1;
        end
        m_cnt = wrap ? 0 : m_cnt + 1;
        if (m_ko == 0 && (m_h[0] == 0 || m_h[1] == 0)) begin
            m_ko = 1;
            m_win = (m_h[0] == 0 ? 2 : 0) + (m_h[1] == 0 ? 1 : 0);
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.hf1 = 2'(m_hf[0]); o.hf2 = 2'(m_hf[1]);
        o.h1  = 3'(m_h[0]);  o.h2  = 3'(m_h[1]);
        o.b1  = 3'(m_b[0]);  o.b2  = 3'(m_b[1]);
        o.ko  = 1'(m_ko);    o.win = 2'(m_win);
        return o;
    endfunction

    function automatic obs_t dut_obs();
        return {p1_hitFlag, p2_hitFlag, p1_health, p2_health, p1_block, p2_block, ko, winner};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("hf=%b/%b hp=%0d/%0d blk=%0d/%0d ko=%b win=%b",
                         o.hf1, o.hf2, o.h1, o.h2, o.b1, o.b2, o.ko, o.win);
    endfunction

    // Drive one cycle of inputs on the falling edge and queue the expected post-edge outputs
    task automatic cycle();
        @(negedge clk);
        rst_n     = rst_v;
        gamestate = 3'(gs);
        p1_state  = 4'(st[0]);
        p2_state  = 4'(st[1]);
        p1_boxes  = pack(0);
        p2_boxes  = pack(1);
        model_step();
        exp_q.push_back(model_obs());
    endtask

    task automatic cycles(input int n);
        repeat (n) cycle();
    endtask

    task automatic rand_box(input int p, input int t);
        int x1, y1;
        if ($urandom_range(0, 7) == 0) begin
            set_box(p, t, $urandom_range(0, 1023), $urandom_range(0, 1023),
                    $urandom_range(0, 1023), $urandom_range(0, 1023));
        end else begin
            x1 = $urandom_range(100, 600);
            y1 = $urandom_range(100, 600);
            set_box(p, t, x1, x1 + $urandom_range(0, 300), y1, y1 + $urandom_range(0, 300));
        end
    endtask

    // Monitor: one registered observation per rising edge
    initial begin
        obs_t e, got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                got = dut_obs();
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL out_check#%0d t=%0t got %s want %s", checks, $time, fmt(got), fmt(e));
                end
            end
        end
    end

    initial begin
        int states[8] = '{0, 1, 2, 4, 7, 9, 10, 12};
        obs_t want;
        model_init();
        st[0] = 0; st[1] = 0;
        // Strike boxes overlap the opponent's main box in both directions
        for (int p = 0; p < 2; p++) begin
            set_box(p, 0, 200, 278, 194, 227);
            set_box(p, 1, 200, 278, 194, 227);
            set_box(p, 2, 230, 283, 170, 320);
        end

        // Reset and round setup
        rst_v = 0; gs = 0; cycles(2);
        rst_v = 1; cycles(2);

        // Round A: single basic hit, held swing, second swing, freeze mid-pulse
        gs = 2;
        st[0] = 4; cycles(10);
        st[0] = 0; cycles(1);
        st[0] = 4; cycles(3);
        st[0] = 0; cycles(1);
        st[0] = 4; cycles(1);
        gs = 3; cycles(4);
        st[0] = 0; cycles(2);
        gs = 2; cycles(2);
        gs = 0; cycles(2);

        // Round B: blocked directional strikes until block runs out, then trade to double KO
        gs = 2; st[1] = 2;
        repeat (4) begin
            st[0] = 7; cycles(2);
            st[0] = 0; cycles(1);
        end
        st[1] = 0;
        st[0] = 7; cycles(1); st[0] = 0; cycles(1);
        repeat (2) begin
            st[1] = 7; cycles(1); st[1] = 0; cycles(1);
        end
        st[0] = 4; st[1] = 4; cycles(3);
        st[0] = 0; st[1] = 0; cycles(1);
        st[0] = 7; st[1] = 4; cycles(2);
        st[0] = 0; st[1] = 0;
        gs = 0; cycles(2);

        // Round C: drain block to 1, then idle through several regen wraps
        gs = 2; st[1] = 2;
        repeat (2) begin
            st[0] = 4; cycles(1); st[0] = 0; cycles(1);
        end
        st[1] = 0; cycles(200);
        gs = 0; cycles(1);

        // Round D: asynchronous reset while a hit flag is showing
        gs = 2; st[0] = 4; cycles(1);
        @(posedge clk);
        #3;
        rst_n = 1'b0; rst_v = 0;
        model_init();
        #1;
        want = model_obs();
        checks++;
        if (dut_obs() !== want) begin
            failures++;
            $display("FAIL async_reset got %s want %s", fmt(dut_obs()), fmt(want));
        end
        cycles(1);
        rst_v = 1; cycles(3);
        st[0] = 0; cycles(1);

        // Random play
        repeat (3000) begin
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1:    gs = 0;
                    2:       gs = 3 + $urandom_range(0, 4);
                    3:       gs = 1;
                    default: gs = 2;
                endcase
            end
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 3) == 0) st[p] = states[$urandom_range(0, 7)];
                for (int t = 0; t < 3; t++)
                    if ($urandom_range(0, 15) == 0) rand_box(p, t);
            end
            rst_v = ($urandom_range(0, 499) != 0);
            cycle();
        end

        rst_v = 1; gs = 0; cycles(2);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
